// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: datapath and debug-module signals of the PC sequencer.
//   slave  : the sequencer (consumes next_pc/ialign/retire/trap/mtvec and debug
//            requests, produces pc/run/halted/resume_ack/dpc/dcause/mepc/trap_taken)
//   master : the surrounding core/debug logic driving the sequencer
`ifndef ISA__XLEN
`define ISA__XLEN 32
`endif

interface pc_sequencer_if #(
  parameter int unsigned Width = `ISA__XLEN
);
  // Datapath side
  logic [Width-1:0] next_pc;
  logic             ialign;
  logic             retire;
  logic             trap;
  logic [Width-1:0] mtvec;
  // Debug module side
  logic             halt_req;
  logic             resume_req;
  logic             step;
  logic             dpc_we;
  logic [Width-1:0] dpc_wdata;
  // Sequencer outputs
  logic [Width-1:0] pc;
  logic             run;
  logic             halted;
  logic             resume_ack;
  logic [Width-1:0] dpc;
  logic [2:0]       dcause;
  logic [Width-1:0] mepc;
  logic             trap_taken;

  modport master (
    output next_pc, ialign, retire, trap, mtvec,
    output halt_req, resume_req, step, dpc_we, dpc_wdata,
    input  pc, run, halted, resume_ack, dpc, dcause, mepc, trap_taken
  );

  modport slave (
    input  next_pc, ialign, retire, trap, mtvec,
    input  halt_req, resume_req, step, dpc_we, dpc_wdata,
    output pc, run, halted, resume_ack, dpc, dcause, mepc, trap_taken
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC and sequences it between normal
// execution, trap redirection and debug halt/step/resume.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   bus - pc_sequencer_if.slave (retirement inputs, debug requests, all
//         registered outputs: pc, run, halted, resume_ack, dpc, dcause,
//         mepc, trap_taken)
`ifndef ISA__XLEN
`define ISA__XLEN 32
`endif

module pc_sequencer #(
  parameter int unsigned      Width       = `ISA__XLEN,
  parameter logic [Width-1:0] ResetVector = '0
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  localparam logic [2:0] CauseHaltReq = 3'd3;
  localparam logic [2:0] CauseStep    = 3'd4;

  typedef enum logic [1:0] {StRun, StStep, StHalted} state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] pc_q, pc_d;
  logic [Width-1:0] dpc_q, dpc_d;
  logic [Width-1:0] mepc_q, mepc_d;
  logic [2:0]       dcause_q, dcause_d;
  logic             run_q, run_d;
  logic             halted_q, halted_d;
  logic             resume_ack_q, resume_ack_d;
  logic             trap_taken_q, trap_taken_d;

  logic             redirect;
  logic [Width-1:0] commit_pc;

  // Trap vector is forced word-aligned; low mtvec bits carry mode, not address.
  logic unused_mtvec;
  assign unused_mtvec = ^bus.mtvec[1:0];

  // trap outranks ialign, but both land on the same vector.
  assign redirect  = bus.trap | bus.ialign;
  assign commit_pc = redirect ? {bus.mtvec[Width-1:2], 2'b00} : bus.next_pc;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    dpc_d        = dpc_q;
    mepc_d       = mepc_q;
    dcause_d     = dcause_q;
    resume_ack_d = 1'b0;
    trap_taken_d = 1'b0;

    unique case (state_q)
      StRun, StStep: begin
        if (bus.retire) begin
          pc_d = commit_pc;
          if (redirect) begin
            mepc_d       = pc_q;
            trap_taken_d = 1'b1;
          end
        end
        if (bus.halt_req) begin
          // Halt on the instruction boundary: dpc is the PC that would run next.
          dpc_d    = bus.retire ? commit_pc : pc_q;
          dcause_d = CauseHaltReq;
          state_d  = StHalted;
        end else if (state_q == StStep && bus.retire) begin
          dpc_d    = commit_pc;
          dcause_d = CauseStep;
          state_d  = StHalted;
        end
      end
      StHalted: begin
        if (bus.dpc_we) begin
          dpc_d = bus.dpc_wdata;
        end
        if (bus.resume_req) begin
          pc_d         = bus.dpc_we ? bus.dpc_wdata : dpc_q;
          resume_ack_d = 1'b1;
          state_d      = bus.step ? StStep : StRun;
        end
      end
      default: state_d = StRun;
    endcase

    run_d    = (state_d != StHalted);
    halted_d = (state_d == StHalted);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      pc_q         <= ResetVector;
      dpc_q        <= '0;
      mepc_q       <= '0;
      dcause_q     <= 3'd0;
      run_q        <= 1'b1;
      halted_q     <= 1'b0;
      resume_ack_q <= 1'b0;
      trap_taken_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      dpc_q        <= dpc_d;
      mepc_q       <= mepc_d;
      dcause_q     <= dcause_d;
      run_q        <= run_d;
      halted_q     <= halted_d;
      resume_ack_q <= resume_ack_d;
      trap_taken_q <= trap_taken_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.run        = run_q;
  assign bus.halted     = halted_q;
  assign bus.resume_ack = resume_ack_q;
  assign bus.dpc        = dpc_q;
  assign bus.dcause     = dcause_q;
  assign bus.mepc       = mepc_q;
  assign bus.trap_taken = trap_taken_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vectors push hand-computed expected output
// snapshots into a queue; a monitor on the falling edge pops and compares.
module tb_pc_sequencer;

  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  pc_sequencer_if #(.Width(W)) bus ();

  pc_sequencer #(
    .Width      (W),
    .ResetVector(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int           tag;
    string        name;
    logic [W-1:0] pc;
    logic         run;
    logic         halted;
    logic         ack;
    logic [W-1:0] dpc;
    logic [2:0]   dcause;
    logic [W-1:0] mepc;
    logic         tt;
  } exp_t;

  exp_t q[$];
  exp_t e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare the head expectation against the DUT in the cycle it targets.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].tag <= cyc) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      if (x.tag != cyc || bus.pc !== x.pc || bus.run !== x.run || bus.halted !== x.halted ||
          bus.resume_ack !== x.ack || bus.dpc !== x.dpc || bus.dcause !== x.dcause ||
          bus.mepc !== x.mepc || bus.trap_taken !== x.tt) begin
        errors++;
        $display("FAIL %s: got pc=%h run=%b halted=%b ack=%b dpc=%h dcause=%0d mepc=%h tt=%b ; want pc=%h run=%b halted=%b ack=%b dpc=%h dcause=%0d mepc=%h tt=%b",
                 x.name, bus.pc, bus.run, bus.halted, bus.resume_ack, bus.dpc, bus.dcause,
                 bus.mepc, bus.trap_taken, x.pc, x.run, x.halted, x.ack, x.dpc, x.dcause,
                 x.mepc, x.tt);
      end
    end
  end

  // Clear all inputs (mtvec kept) and default the expected pulses to 0.
  task automatic clr();
    rst            = 1'b0;
    bus.next_pc    = '0;
    bus.ialign     = 1'b0;
    bus.retire     = 1'b0;
    bus.trap       = 1'b0;
    bus.halt_req   = 1'b0;
    bus.resume_req = 1'b0;
    bus.step       = 1'b0;
    bus.dpc_we     = 1'b0;
    bus.dpc_wdata  = '0;
    e.ack          = 1'b0;
    e.tt           = 1'b0;
  endtask

  // Apply current inputs over one rising edge and queue the expected result.
  task automatic cycle(input string name);
    @(posedge clk);
    #1;
    e.tag  = cyc;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic exp_reset();
    e.pc = 32'h0; e.run = 1'b1; e.halted = 1'b0; e.ack = 1'b0;
    e.dpc = 32'h0; e.dcause = 3'd0; e.mepc = 32'h0; e.tt = 1'b0;
  endtask

  task automatic exp_halt(input logic [W-1:0] d, input logic [2:0] c);
    e.run = 1'b0; e.halted = 1'b1; e.dpc = d; e.dcause = c;
  endtask

  task automatic exp_running();
    e.run = 1'b1; e.halted = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.mtvec = 32'h803;
    clr();
    rst = 1'b1;
    exp_reset();
    cycle("reset");

    // Normal retire.
    clr(); bus.retire = 1'b1; bus.next_pc = 32'h104;
    e.pc = 32'h104; cycle("retire_104");
    clr(); cycle("idle_hold");
    clr(); bus.retire = 1'b1; bus.next_pc = 32'h200;
    e.pc = 32'h200; cycle("retire_200");

    // Misaligned next_pc redirects to mtvec with low bits cleared.
    clr(); bus.retire = 1'b1; bus.ialign = 1'b1; bus.next_pc = 32'h202;
    e.pc = 32'h800; e.mepc = 32'h200; e.tt = 1'b1; cycle("ialign_trap");
    clr(); cycle("trap_taken_drops");
    clr(); bus.trap = 1'b1; bus.next_pc = 32'h999;
    cycle("trap_without_retire");

    // trap and ialign together.
    clr(); bus.retire = 1'b1; bus.trap = 1'b1; bus.ialign = 1'b1; bus.next_pc = 32'h804;
    bus.mtvec = 32'hA01;
    e.pc = 32'hA00; e.mepc = 32'h800; e.tt = 1'b1; cycle("trap_and_ialign");
    bus.mtvec = 32'h803;
    clr(); bus.retire = 1'b1; bus.next_pc = 32'h300;
    e.pc = 32'h300; cycle("retire_300");

    // Halt with a retire in the same cycle.
    clr(); bus.halt_req = 1'b1; bus.retire = 1'b1; bus.next_pc = 32'h304;
    e.pc = 32'h304; exp_halt(32'h304, 3'd3); cycle("halt_with_retire");
    clr(); bus.halt_req = 1'b1; bus.retire = 1'b1; bus.trap = 1'b1; bus.next_pc = 32'h999;
    cycle("halted_ignores_retire");
    clr(); bus.dpc_we = 1'b1; bus.dpc_wdata = 32'h1000;
    e.dpc = 32'h1000; cycle("dpc_write");

    // Held resume: one ack, then nothing more; dpc_we ignored while running.
    clr(); bus.resume_req = 1'b1;
    e.pc = 32'h1000; e.ack = 1'b1; exp_running(); cycle("resume_1");
    clr(); bus.resume_req = 1'b1; bus.dpc_we = 1'b1; bus.dpc_wdata = 32'h2222;
    cycle("resume_held_2");
    clr(); bus.resume_req = 1'b1;
    cycle("resume_held_3");

    // Halt without retire.
    clr(); bus.retire = 1'b1; bus.next_pc = 32'h400;
    e.pc = 32'h400; cycle("retire_400");
    clr(); bus.halt_req = 1'b1;
    exp_halt(32'h400, 3'd3); cycle("halt_no_retire");

    // Step: resume with dpc_we in the same cycle, then exactly one retire.
    clr(); bus.dpc_we = 1'b1; bus.dpc_wdata = 32'h480;
    e.dpc = 32'h480; cycle("dpc_write_480");
    clr(); bus.resume_req = 1'b1; bus.step = 1'b1; bus.dpc_we = 1'b1; bus.dpc_wdata = 32'h500;
    e.pc = 32'h500; e.dpc = 32'h500; e.ack = 1'b1; exp_running(); cycle("resume_step_wdata");
    clr(); bus.retire = 1'b1; bus.next_pc = 32'h504; bus.step = 1'b1;
    e.pc = 32'h504; exp_halt(32'h504, 3'd4); cycle("step_retire");
    clr(); bus.retire = 1'b1; bus.next_pc = 32'h508;
    cycle("second_retire_blocked");

    // Step with halt_req on the retire: haltreq cause wins.
    clr(); bus.resume_req = 1'b1; bus.step = 1'b1;
    e.ack = 1'b1; exp_running(); cycle("resume_step_2");
    clr(); bus.halt_req = 1'b1; bus.retire = 1'b1; bus.next_pc = 32'h508; bus.step = 1'b1;
    e.pc = 32'h508; exp_halt(32'h508, 3'd3); cycle("step_retire_haltreq");

    // Trapping step.
    clr(); bus.resume_req = 1'b1; bus.step = 1'b1;
    e.ack = 1'b1; exp_running(); cycle("resume_step_3");
    clr(); bus.retire = 1'b1; bus.trap = 1'b1; bus.next_pc = 32'h50C; bus.step = 1'b1;
    e.pc = 32'h800; e.mepc = 32'h508; e.tt = 1'b1; exp_halt(32'h800, 3'd4);
    cycle("step_trap");

    // Halt in step without retire.
    clr(); bus.resume_req = 1'b1; bus.step = 1'b1;
    e.ack = 1'b1; exp_running(); cycle("resume_step_4");
    clr(); bus.halt_req = 1'b1;
    exp_halt(32'h800, 3'd3); cycle("step_halt_no_retire");

    // Reset while halted.
    clr(); rst = 1'b1;
    exp_reset(); cycle("reset_in_halt");

    // Reset while stepping, then confirm RUN (two retires accepted).
    clr(); bus.retire = 1'b1; bus.next_pc = 32'h40;
    e.pc = 32'h40; cycle("retire_40");
    clr(); bus.halt_req = 1'b1;
    exp_halt(32'h40, 3'd3); cycle("halt_40");
    clr(); bus.resume_req = 1'b1; bus.step = 1'b1;
    e.ack = 1'b1; exp_running(); cycle("resume_step_5");
    clr(); rst = 1'b1; bus.retire = 1'b1; bus.next_pc = 32'h44;
    exp_reset(); cycle("reset_in_step");
    clr(); bus.retire = 1'b1; bus.next_pc = 32'h10;
    e.pc = 32'h10; cycle("run_after_reset_1");
    clr(); bus.retire = 1'b1; bus.next_pc = 32'h14;
    e.pc = 32'h14; cycle("run_after_reset_2");
    clr();

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      errors += q.size();
      checks += q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the architectural program counter and sequences it between normal execution, trap redirection and debug halt/step/resume. Consumes the next-PC value and misalignment flag produced by the PC ALU at instruction retirement. Provides the debug PC (dpc), debug cause, trap PC (mepc) and a run enable to the fetch/execute stages. Sits between the core datapath and the debug module interface.

Parameters:
Width, `ISA__XLEN, datapath and PC width
ResetVector, 0, PC value after reset

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
next_pc  input  Width  next PC from PC ALU for the retiring instruction
ialign  input  1  next_pc misaligned (from PC ALU)
retire  input  1  instruction completes this cycle
trap  input  1  synchronous exception on current instruction (non-alignment)
mtvec  input  Width  trap vector base
halt_req  input  1  debug halt request (level)
resume_req  input  1  debug resume request (level, honoured once per halt)
step  input  1  dcsr.step
dpc_we  input  1  debugger write to dpc
dpc_wdata  input  Width  dpc write data
pc  output  Width  current PC
run  output  1  core may fetch/retire
halted  output  1  core in debug halt
resume_ack  output  1  one-cycle pulse on resume
dpc  output  Width  debug PC
dcause  output  3  dcsr.cause (3 = haltreq, 4 = step)
mepc  output  Width  PC of trapping instruction
trap_taken  output  1  one-cycle pulse on trap redirect

Behaviour:
- All outputs registered. Reset: pc=ResetVector, state RUN, run=1, halted=0, resume_ack=0, dpc=0, dcause=0, mepc=0, trap_taken=0. Reset mid-halt or mid-step returns to RUN.
- States: RUN, STEP, HALTED. run=1 in RUN/STEP, 0 in HALTED; halted=1 only in HALTED.
- Commit (RUN/STEP, retire=1): trap=1 or ialign=1 -> pc<={mtvec[Width-1:2],2'b00}, mepc<=pc, trap_taken<=1. trap takes priority over ialign; both give the same redirect. Otherwise pc<=next_pc. Result available one cycle after retire.
- trap with retire=0 is ignored; the datapath asserts trap together with retire.
- RUN + halt_req: halt at the instruction boundary. If retire is high in the same cycle, commit first and set dpc=committed PC (redirect target if trapping). Else dpc<=pc. dcause<=3, go HALTED next cycle.
- STEP: at most one instruction. On retire, commit normally, dpc<=committed PC, dcause<=4, go HALTED. halt_req with retire=0 in STEP -> HALTED, dpc<=pc, dcause<=3. halt_req together with retire -> commit, dcause<=3 (haltreq outranks step).
- HALTED: retire, trap and halt_req ignored. dpc_we -> dpc<=dpc_wdata. resume_req -> pc<=dpc (or dpc_wdata if dpc_we in the same cycle), resume_ack<=1 for one cycle, state<=STEP if step=1 else RUN. A held resume_req causes no further action after leaving HALTED.
- dpc_we outside HALTED ignored. resume_req outside HALTED ignored.
- No width extension. All PC arithmetic belongs to the PC ALU; this block only selects and registers values.

Test Plan:
- Reset, then retire with next_pc=0x104, ialign=0 -> pc=0x0 after reset, pc=0x104 the cycle after retire, trap_taken=0.
- pc=0x200, retire with ialign=1, mtvec=0x803 -> pc=0x800, mepc=0x200, trap_taken pulses for one cycle.
- pc=0x300, halt_req with retire=1, next_pc=0x304 -> halted=1, run=0, dpc=0x304, dcause=3. halt_req with no retire at pc=0x400 -> dpc=0x400.
- Halted, dpc_we with 0x1000, then resume_req held for 3 cycles, step=0 -> pc=0x1000, a single resume_ack pulse, run=1, stays in RUN.
- Halted at dpc=0x500, resume with step=1, then retire with next_pc=0x504 -> exactly one retire accepted, halted=1, dpc=0x504, dcause=4. Repeat with halt_req during the step retire -> dcause=3.
- Assert rst while HALTED and while in STEP -> next cycle pc=ResetVector, run=1, halted=0, dcause=0.
